// File: rtl/sha256_pkg.sv
// SHA-256 constants, round primitives and controller state encoding shared by the hashing engine.
// Pure combinational helpers: zero latency, no flow control.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef logic [7:0][31:0] hvec_t;  // index 0 = a / H0

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_COMP, S_ADD, S_PASS2, S_WRITE
  } state_e;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Concatenation runs H7 down to H0 so that IV[0] is H0.
  localparam hvec_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                          32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  function automatic word_t rotr(word_t x, int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t sigma0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t big_sigma0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(word_t e, word_t f, word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(word_t a, word_t b, word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic hvec_t round_f(hvec_t s, word_t k, word_t w);
    word_t t1;
    word_t t2;
    hvec_t n;
    t1 = s[7] + big_sigma1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
    t2 = big_sigma0(s[0]) + maj(s[0], s[1], s[2]);
    n[0] = t1 + t2;
    n[1] = s[0];
    n[2] = s[1];
    n[3] = s[2];
    n[4] = s[3] + t1;
    n[5] = s[4];
    n[6] = s[5];
    n[7] = s[6];
    return n;
  endfunction

endpackage

// File: rtl/sha256_multi_if.sv
// Job-control and shared-memory bus of the hashing engine; slave = engine view, master = host/memory view.
// Wires only: zero latency; the engine never stalls on the memory (fixed synchronous-read timing).
interface sha256_multi_if #(parameter int ADDR_W = 16);
  logic              start;
  logic [7:0]        num_words;
  logic              double_hash;
  logic [ADDR_W-1:0] input_addr;
  logic [ADDR_W-1:0] hash_addr;
  logic              done;
  logic              memory_clk;
  logic              enable_write;
  logic [ADDR_W-1:0] memory_addr;
  logic [31:0]       memory_write_data;
  logic [31:0]       memory_read_data;

  modport slave (
    input  start, num_words, double_hash, input_addr, hash_addr, memory_read_data,
    output done, memory_clk, enable_write, memory_addr, memory_write_data
  );

  modport master (
    output start, num_words, double_hash, input_addr, hash_addr, memory_read_data,
    input  done, memory_clk, enable_write, memory_addr, memory_write_data
  );
endinterface

// File: rtl/sha256_wsched.sv
// 16-word rolling message schedule; w_dat is W[r] combinationally, expanded words overwrite slot r mod 16.
// Loads and advances take effect on the next edge; no backpressure.
module sha256_wsched
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_vld,
  input  logic [3:0]        ld_idx,
  input  word_t             ld_dat,
  input  logic              blk_vld,
  input  logic [15:0][31:0] blk_dat,
  input  logic              adv,
  input  logic [5:0]        r,
  output word_t             w_dat
);

  logic [15:0][31:0] sched_q, sched_d;
  logic [3:0]        slot;
  word_t             w_new;

  assign slot = r[3:0];

  always_comb begin
    sched_d = sched_q;
    // Slots r-2, r-7, r+1 and r hold W[r-2], W[r-7], W[r-15] and W[r-16].
    w_new = sigma1(sched_q[slot - 4'd2]) + sched_q[slot - 4'd7]
          + sigma0(sched_q[slot + 4'd1]) + sched_q[slot];
    w_dat = (r[5:4] == 2'd0) ? sched_q[slot] : w_new;
    if (blk_vld) begin
      sched_d = blk_dat;
    end else if (ld_vld) begin
      sched_d[ld_idx] = ld_dat;
    end else if (adv && (r[5:4] != 2'd0)) begin
      sched_d[slot] = w_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sched_q <= '0;
    else        sched_q <= sched_d;
  end

endmodule

// File: rtl/sha256_multi.sv
// Runtime-length SHA-256 / SHA-256d engine: fetch+pad, 64 rounds, add per block, then 8-word digest write.
// Latency 1 + sum(fetch+65) + 8 (+66 for double hash); start ignored while busy, done high only in IDLE.
module sha256_multi
  import sha256_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sha256_multi_if.slave      bus
);

  state_e            state_q, state_d;
  logic [7:0]        nw_q, nw_d;
  logic [4:0]        nblk_q, nblk_d;
  logic [8:0]        wcnt_q, wcnt_d;
  logic              rd_wait_q, rd_wait_d;
  logic              dbl_q, dbl_d, pass2_q, pass2_d;
  logic [ADDR_W-1:0] in_addr_q, in_addr_d, out_addr_q, out_addr_d;
  hvec_t             h_q, h_d, wk_q, wk_d;
  logic [5:0]        r_q, r_d;
  logic [2:0]        k_q, k_d;

  logic              ld_vld, blk_vld, adv, we;
  word_t             ld_dat, w_dat, mwdata, pad_word;
  logic [15:0][31:0] blk_dat;
  logic [ADDR_W-1:0] maddr;
  logic [7:0]        nw_clamp;
  logic [8:0]        nw_p2, blk_words;

  sha256_wsched u_wsched (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_vld  (ld_vld),
    .ld_idx  (wcnt_q[3:0]),
    .ld_dat  (ld_dat),
    .blk_vld (blk_vld),
    .blk_dat (blk_dat),
    .adv     (adv),
    .r       (r_q),
    .w_dat   (w_dat)
  );

  assign bus.memory_clk        = clk;
  assign bus.done              = (state_q == S_IDLE);
  assign bus.enable_write      = we;
  assign bus.memory_addr       = maddr;
  assign bus.memory_write_data = mwdata;

  always_comb begin
    state_d    = state_q;
    nw_d       = nw_q;
    nblk_d     = nblk_q;
    wcnt_d     = wcnt_q;
    rd_wait_d  = rd_wait_q;
    dbl_d      = dbl_q;
    pass2_d    = pass2_q;
    in_addr_d  = in_addr_q;
    out_addr_d = out_addr_q;
    h_d        = h_q;
    wk_d       = wk_q;
    r_d        = r_q;
    k_d        = k_q;
    ld_vld     = 1'b0;
    ld_dat     = '0;
    blk_vld    = 1'b0;
    blk_dat    = '0;
    adv        = 1'b0;
    we         = 1'b0;
    maddr      = '0;
    mwdata     = '0;

    nw_clamp  = (bus.num_words > 8'(MAX_WORDS)) ? 8'(MAX_WORDS) : bus.num_words;
    nw_p2     = {1'b0, nw_clamp} + 9'd2;
    blk_words = {nblk_q, 4'b0};
    if (wcnt_q == {1'b0, nw_q})              pad_word = 32'h8000_0000;
    else if (wcnt_q == blk_words - 9'd1)     pad_word = {19'b0, nw_q, 5'b0};
    else                                     pad_word = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          nw_d       = nw_clamp;
          nblk_d     = nw_p2[8:4] + 5'd1;
          wcnt_d     = '0;
          rd_wait_d  = 1'b0;
          dbl_d      = bus.double_hash;
          pass2_d    = 1'b0;
          in_addr_d  = bus.input_addr;
          out_addr_d = bus.hash_addr;
          h_d        = IV;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (wcnt_q < {1'b0, nw_q}) begin
          // Address is held over REQ and WAIT; data lands at the end of WAIT.
          maddr     = in_addr_q + ADDR_W'(wcnt_q);
          rd_wait_d = !rd_wait_q;
          ld_vld    = rd_wait_q;
          ld_dat    = bus.memory_read_data;
        end else begin
          ld_vld = 1'b1;
          ld_dat = pad_word;
        end
        if (ld_vld) begin
          wcnt_d = wcnt_q + 9'd1;
          if (wcnt_q[3:0] == 4'd15) begin
            wk_d    = h_q;
            r_d     = '0;
            state_d = S_COMP;
          end
        end
      end
      S_COMP: begin
        adv  = 1'b1;
        wk_d = round_f(wk_q, K[r_q], w_dat);
        r_d  = r_q + 6'd1;
        if (r_q == 6'd63) state_d = S_ADD;
      end
      S_ADD: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wk_q[i];
        if (!pass2_q && (wcnt_q != blk_words)) state_d = S_FETCH;
        else if (dbl_q && !pass2_q)            state_d = S_PASS2;
        else begin
          k_d     = '0;
          state_d = S_WRITE;
        end
      end
      S_PASS2: begin
        // Second pass hashes the 256-bit first digest as a single pre-padded block.
        blk_vld = 1'b1;
        blk_dat = {32'd256, 192'b0, 32'h8000_0000, h_q};
        h_d     = IV;
        wk_d    = IV;
        r_d     = '0;
        pass2_d = 1'b1;
        state_d = S_COMP;
      end
      S_WRITE: begin
        we     = 1'b1;
        maddr  = out_addr_q + ADDR_W'(k_q);
        mwdata = h_q[k_q];
        k_d    = k_q + 3'd1;
        if (k_q == 3'd7) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      nw_q       <= '0;
      nblk_q     <= '0;
      wcnt_q     <= '0;
      rd_wait_q  <= 1'b0;
      dbl_q      <= 1'b0;
      pass2_q    <= 1'b0;
      in_addr_q  <= '0;
      out_addr_q <= '0;
      h_q        <= '0;
      wk_q       <= '0;
      r_q        <= '0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      nw_q       <= nw_d;
      nblk_q     <= nblk_d;
      wcnt_q     <= wcnt_d;
      rd_wait_q  <= rd_wait_d;
      dbl_q      <= dbl_d;
      pass2_q    <= pass2_d;
      in_addr_q  <= in_addr_d;
      out_addr_q <= out_addr_d;
      h_q        <= h_d;
      wk_q       <= wk_d;
      r_q        <= r_d;
      k_q        <= k_d;
    end
  end

endmodule
